reg_file_sb: RTL and testbench

Parametrised multi-write register file with an integrated scoreboard, the successor to the CPU's 8x8-bit, single-write register file. It provides two asynchronous read ports, two synchronous write ports with fixed priority, optional same-cycle write-to-read bypass, an optional hardwired-zero register, and per-register busy bits. The busy bits let the control unit hold an instruction until its operands are available. It sits between the instruction decoder/control unit and the ALU operand muxes.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/reg_file_rdport.sv | 52 +++++
 rtl/reg_file_sb.sv | 116 +++++++++++
 tb/tb_reg_file_sb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU defaults for register-file geometry and the architectural reset value.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    localparam logic [DATA_W_DEF-1:0] RESET_VALUE = {DATA_W_DEF{1'b0}};

endpackage

// File: rtl/reg_file_rdport.sv
// One asynchronous read port: zero register, write bypass (port 1 over port 0)
// and operand-valid generation from the scoreboard busy bit.
module reg_file_rdport #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_data_i,
    input  logic              stored_busy_i,
    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    localparam bit USE_ZERO = (ZERO_REG != 0);
    localparam bit USE_BYP  = (BYPASS != 0);

    logic is_zero;
    logic hit1;
    logic hit0;

    assign is_zero = USE_ZERO && (rd_addr_i == {ADDR_W{1'b0}});
    assign hit1    = USE_BYP && wr1_en_i && (wr1_addr_i == rd_addr_i);
    assign hit0    = USE_BYP && wr0_en_i && (wr0_addr_i == rd_addr_i);

    // Read data and valid selection; a bypassed value is by definition not pending.
    always_comb begin
        rd_data_o  = stored_data_i;
        rd_valid_o = ~stored_busy_i;
        if (is_zero) begin
            rd_data_o  = {DATA_W{1'b0}};
            rd_valid_o = 1'b1;
        end else if (hit1) begin
            rd_data_o  = wr1_data_i;
            rd_valid_o = 1'b1;
        end else if (hit0) begin
            rd_data_o  = wr0_data_i;
            rd_valid_o = 1'b1;
        end else begin
            rd_data_o  = stored_data_i;
            rd_valid_o = ~stored_busy_i;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Dual-write register file with per-register busy scoreboard and two bypassing
// asynchronous read ports.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE0,
    input  logic [ADDR_W-1:0] INADDRESS0,
    input  logic [DATA_W-1:0] IN0,
    input  logic              WRITE1,
    input  logic [ADDR_W-1:0] INADDRESS1,
    input  logic [DATA_W-1:0] IN1,
    input  logic              RESERVE,
    input  logic [ADDR_W-1:0] RESERVEADDRESS,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1_VALID,
    output logic              OUT2_VALID,
    output logic [DEPTH-1:0]  BUSY
);

    // Register 0 is excluded from every update when it is hardwired to zero.
    localparam logic [DEPTH-1:0] WR_MASK = (ZERO_REG != 0) ?
        {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  we0;
    logic [DEPTH-1:0]  we1;
    logic [DEPTH-1:0]  rsv;

    // Next-state: reset beats everything, port 1 beats port 0, reserve beats write-clear.
    always_comb begin
        we0    = {DEPTH{1'b0}};
        we1    = {DEPTH{1'b0}};
        rsv    = {DEPTH{1'b0}};
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            we0[i] = WRITE0  && (INADDRESS0     == ADDR_W'(i)) && WR_MASK[i];
            we1[i] = WRITE1  && (INADDRESS1     == ADDR_W'(i)) && WR_MASK[i];
            rsv[i] = RESERVE && (RESERVEADDRESS == ADDR_W'(i)) && WR_MASK[i];
            mem_d[i] = mem_q[i];
            if (RESET) begin
                mem_d[i]  = {DATA_W{1'b0}};
                busy_d[i] = 1'b0;
            end else begin
                if (we1[i]) begin
                    mem_d[i] = IN1;
                end else if (we0[i]) begin
                    mem_d[i] = IN0;
                end else begin
                    mem_d[i] = mem_q[i];
                end
                if (rsv[i]) begin
                    busy_d[i] = 1'b1;
                end else if (we0[i] || we1[i]) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
    end

    // Storage and scoreboard registers.
    always_ff @(posedge CLK) begin
        mem_q  <= mem_d;
        busy_q <= busy_d;
    end

    assign BUSY = busy_q;

    reg_file_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd1 (
        .rd_addr_i    (OUT1ADDRESS),
        .stored_data_i(mem_q[OUT1ADDRESS]),
        .stored_busy_i(busy_q[OUT1ADDRESS]),
        .wr0_en_i     (WRITE0),
        .wr0_addr_i   (INADDRESS0),
        .wr0_data_i   (IN0),
        .wr1_en_i     (WRITE1),
        .wr1_addr_i   (INADDRESS1),
        .wr1_data_i   (IN1),
        .rd_data_o    (OUT1),
        .rd_valid_o   (OUT1_VALID)
    );

    reg_file_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd2 (
        .rd_addr_i    (OUT2ADDRESS),
        .stored_data_i(mem_q[OUT2ADDRESS]),
        .stored_busy_i(busy_q[OUT2ADDRESS]),
        .wr0_en_i     (WRITE0),
        .wr0_addr_i   (INADDRESS0),
        .wr0_data_i   (IN0),
        .wr1_en_i     (WRITE1),
        .wr1_addr_i   (INADDRESS1),
        .wr1_data_i   (IN1),
        .rd_data_o    (OUT2),
        .rd_valid_o   (OUT2_VALID)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three configurations driven from one stimulus stream,
// checked against directed vectors and a behavioural register-file model.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, w0, w1, rsv;
    logic [4:0]  a0, a1, ra, r1, r2;
    logic [15:0] d0, d1;

    logic [7:0]  o1_a, o2_a, o1_z, o2_z, busy_a, busy_z;
    logic        v1_a, v2_a, v1_z, v2_z, v1_w, v2_w;
    logic [15:0] o1_w, o2_w;
    logic [31:0] busy_w;

    // cfg 0: 8x8 bypass; cfg 1: 8x8 no bypass, zero reg; cfg 2: 16x32 bypass
    reg_file_sb #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLK(clk), .RESET(rst), .WRITE0(w0), .INADDRESS0(a0[2:0]), .IN0(d0[7:0]),
        .WRITE1(w1), .INADDRESS1(a1[2:0]), .IN1(d1[7:0]), .RESERVE(rsv),
        .RESERVEADDRESS(ra[2:0]), .OUT1ADDRESS(r1[2:0]), .OUT2ADDRESS(r2[2:0]),
        .OUT1(o1_a), .OUT2(o2_a), .OUT1_VALID(v1_a), .OUT2_VALID(v2_a), .BUSY(busy_a));

    reg_file_sb #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(1)) dut_z (
        .CLK(clk), .RESET(rst), .WRITE0(w0), .INADDRESS0(a0[2:0]), .IN0(d0[7:0]),
        .WRITE1(w1), .INADDRESS1(a1[2:0]), .IN1(d1[7:0]), .RESERVE(rsv),
        .RESERVEADDRESS(ra[2:0]), .OUT1ADDRESS(r1[2:0]), .OUT2ADDRESS(r2[2:0]),
        .OUT1(o1_z), .OUT2(o2_z), .OUT1_VALID(v1_z), .OUT2_VALID(v2_z), .BUSY(busy_z));

    reg_file_sb #(.DATA_W(16), .DEPTH(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(0)) dut_w (
        .CLK(clk), .RESET(rst), .WRITE0(w0), .INADDRESS0(a0), .IN0(d0),
        .WRITE1(w1), .INADDRESS1(a1), .IN1(d1), .RESERVE(rsv),
        .RESERVEADDRESS(ra), .OUT1ADDRESS(r1), .OUT2ADDRESS(r2),
        .OUT1(o1_w), .OUT2(o2_w), .OUT1_VALID(v1_w), .OUT2_VALID(v2_w), .BUSY(busy_w));

    logic [2:0][15:0] g_o1, g_o2;
    logic [2:0]       g_v1, g_v2;
    logic [2:0][31:0] g_busy;
    assign g_o1[0] = {8'h00, o1_a};  assign g_o2[0] = {8'h00, o2_a};
    assign g_o1[1] = {8'h00, o1_z};  assign g_o2[1] = {8'h00, o2_z};
    assign g_o1[2] = o1_w;           assign g_o2[2] = o2_w;
    assign g_v1    = {v1_w, v1_z, v1_a};
    assign g_v2    = {v2_w, v2_z, v2_a};
    assign g_busy[0] = {24'h0, busy_a};
    assign g_busy[1] = {24'h0, busy_z};
    assign g_busy[2] = busy_w;

    // Reference model state, sized for the largest configuration.
    int          cfg_depth [3] = '{8, 8, 32};
    int          cfg_byp   [3] = '{1, 0, 1};
    int          cfg_zero  [3] = '{0, 1, 0};
    logic [15:0] cfg_mask  [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
    logic [15:0] m_mem  [3][32];
    logic [31:0] m_busy [3];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int bypass_src(input int c, input int a);
        if (cfg_byp[c] == 0) return 0;
        if (w1 && (int'(a1) % cfg_depth[c]) == a) return 1;
        if (w0 && (int'(a0) % cfg_depth[c]) == a) return 2;
        return 0;
    endfunction

    function automatic logic [15:0] exp_read(input int c, input logic [4:0] radr);
        int a = int'(radr) % cfg_depth[c];
        if (cfg_zero[c] != 0 && a == 0) return 16'h0000;
        case (bypass_src(c, a))
            1:       return d1 & cfg_mask[c];
            2:       return d0 & cfg_mask[c];
            default: return m_mem[c][a];
        endcase
    endfunction

    function automatic logic exp_valid(input int c, input logic [4:0] radr);
        int a = int'(radr) % cfg_depth[c];
        if (cfg_zero[c] != 0 && a == 0) return 1'b1;
        if (bypass_src(c, a) != 0) return 1'b1;
        return ~m_busy[c][a];
    endfunction

    task automatic model_step(input int c);
        for (int a = 0; a < cfg_depth[c]; a++) begin
            bit h0 = w0  && (int'(a0) % cfg_depth[c]) == a;
            bit h1 = w1  && (int'(a1) % cfg_depth[c]) == a;
            bit hr = rsv && (int'(ra) % cfg_depth[c]) == a;
            if (rst) begin
                m_mem[c][a]  = 16'h0000;
                m_busy[c][a] = 1'b0;
            end else if (!(cfg_zero[c] != 0 && a == 0)) begin
                if (h1)      m_mem[c][a] = d1 & cfg_mask[c];
                else if (h0) m_mem[c][a] = d0 & cfg_mask[c];
                if (hr)            m_busy[c][a] = 1'b1;
                else if (h0 || h1) m_busy[c][a] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("cfg%0d out1 r%0d", c, r1), {16'h0, g_o1[c]}, {16'h0, exp_read(c, r1)});
            chk($sformatf("cfg%0d out2 r%0d", c, r2), {16'h0, g_o2[c]}, {16'h0, exp_read(c, r2)});
            chk($sformatf("cfg%0d valid1", c), {31'h0, g_v1[c]}, {31'h0, exp_valid(c, r1)});
            chk($sformatf("cfg%0d valid2", c), {31'h0, g_v2[c]}, {31'h0, exp_valid(c, r2)});
            chk($sformatf("cfg%0d busy", c), g_busy[c], m_busy[c]);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 3; c++) model_step(c);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; w0 = 1'b0; w1 = 1'b0; rsv = 1'b0;
        a0 = 5'd0; a1 = 5'd0; ra = 5'd0; d0 = 16'h0000; d1 = 16'h0000;
    endtask

    typedef struct {
        logic       rst;
        logic       w0;  logic [2:0] a0; logic [7:0] d0;
        logic       w1;  logic [2:0] a1; logic [7:0] d1;
        logic       rsv; logic [2:0] ra;
        logic [2:0] r1;  logic [2:0] r2;
        logic [7:0] e1;  logic       ev1;
        logic [7:0] e2;  logic       ev2;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // rst w0 a0 d0 w1 a1 d1 rsv ra r1 r2 | e1 ev1 e2 ev2 busy  (cfg 0, same-cycle view)
        tbl[0]  = '{1'b0,1'b1,3'd2,8'h5F,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd2, 8'h5F,1'b1,8'h5F,1'b1,8'h00};
        tbl[1]  = '{1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd2, 8'h5F,1'b1,8'h5F,1'b1,8'h00};
        tbl[2]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd3, 8'h00,1'b1,8'h00,1'b1,8'h00};
        tbl[3]  = '{1'b0,1'b1,3'd3,8'h11,1'b1,3'd3,8'h22,1'b0,3'd0,3'd3,3'd3, 8'h22,1'b1,8'h22,1'b1,8'h00};
        tbl[4]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd3,3'd3, 8'h22,1'b1,8'h22,1'b1,8'h00};
        tbl[5]  = '{1'b0,1'b1,3'd3,8'h33,1'b0,3'd0,8'h00,1'b0,3'd0,3'd3,3'd4, 8'h33,1'b1,8'h00,1'b1,8'h00};
        tbl[6]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd4,3'd4,3'd4, 8'h00,1'b1,8'h00,1'b1,8'h00};
        tbl[7]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd3,3'd4, 8'h33,1'b1,8'h00,1'b0,8'h10};
        tbl[8]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd4,8'h06,1'b0,3'd0,3'd4,3'd4, 8'h06,1'b1,8'h06,1'b1,8'h10};
        tbl[9]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd5,3'd4, 8'h00,1'b1,8'h06,1'b1,8'h00};
        tbl[10] = '{1'b0,1'b1,3'd5,8'hAB,1'b0,3'd0,8'h00,1'b1,3'd5,3'd5,3'd5, 8'hAB,1'b1,8'hAB,1'b1,8'h00};
        tbl[11] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd5,3'd5, 8'hAB,1'b0,8'hAB,1'b0,8'h20};
        tbl[12] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd6,3'd6,3'd5, 8'h00,1'b1,8'hAB,1'b0,8'h20};
        tbl[13] = '{1'b1,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd6,3'd5, 8'h00,1'b0,8'hAB,1'b0,8'h60};
        tbl[14] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd6,3'd5, 8'h00,1'b1,8'h00,1'b1,8'h00};

        idle();
        r1 = 5'd0; r2 = 5'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        tick();

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst;
            w0  = tbl[i].w0;  a0 = {2'b00, tbl[i].a0}; d0 = {8'h00, tbl[i].d0};
            w1  = tbl[i].w1;  a1 = {2'b00, tbl[i].a1}; d1 = {8'h00, tbl[i].d1};
            rsv = tbl[i].rsv; ra = {2'b00, tbl[i].ra};
            r1  = {2'b00, tbl[i].r1}; r2 = {2'b00, tbl[i].r2};
            @(negedge clk);
            chk($sformatf("vec%0d out1", i),   {24'h0, o1_a},   {24'h0, tbl[i].e1});
            chk($sformatf("vec%0d valid1", i), {31'h0, v1_a},   {31'h0, tbl[i].ev1});
            chk($sformatf("vec%0d out2", i),   {24'h0, o2_a},   {24'h0, tbl[i].e2});
            chk($sformatf("vec%0d valid2", i), {31'h0, v2_a},   {31'h0, tbl[i].ev2});
            chk($sformatf("vec%0d busy", i),   {24'h0, busy_a}, {24'h0, tbl[i].eb});
            check_all();
            tick();
        end

        // Zero register: write and reserve of r0 are discarded only where hardwired.
        idle();
        w0 = 1'b1; a0 = 5'd0; d0 = 16'h00FF; rsv = 1'b1; ra = 5'd0; r1 = 5'd0; r2 = 5'd0;
        settle();
        tick();
        idle();
        settle();
        chk("zero out1",   {24'h0, o1_z},      32'h0000_0000);
        chk("zero valid1", {31'h0, v1_z},      32'h0000_0001);
        chk("zero busy0",  {31'h0, busy_z[0]}, 32'h0000_0000);
        chk("nozero out1", {24'h0, o1_a},      32'h0000_00FF);
        chk("nozero busy0",{31'h0, busy_a[0]}, 32'h0000_0001);
        tick();

        // Wide configuration: top register written, its neighbour untouched.
        w0 = 1'b1; a0 = 5'd31; d0 = 16'hBEEF; r1 = 5'd31; r2 = 5'd30;
        settle();
        tick();
        idle();
        settle();
        chk("wide r31", {16'h0, o1_w}, 32'h0000_BEEF);
        chk("wide r30", {16'h0, o2_w}, 32'h0000_0000);
        chk("wide v31", {31'h0, v1_w}, 32'h0000_0001);
        tick();

        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            w0  = ($urandom_range(0, 1) == 1);
            w1  = ($urandom_range(0, 2) == 0);
            rsv = ($urandom_range(0, 2) == 0);
            a0  = 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            d0  = 16'($urandom);
            d1  = 16'($urandom);
            r1  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
